// File: rtl/smpl_deci_pk.sv
// Sample decimator with plain / peak-max / peak-min window reduction.
// Each window of num+1 samples yields one registered output; div2 emits every second window.
module smpl_deci_pk #(
  parameter int DW = 8,
  parameter int CW = 16
) (
  input  logic          clk,
  input  logic          nrst,
  input  logic          en,
  input  logic [CW-1:0] num,
  input  logic [1:0]    mode,
  input  logic          div2,
  input  logic [DW-1:0] din,
  output logic [DW-1:0] dout,
  output logic          dvalid,
  output logic          out2
);

  logic [CW-1:0] cnt_q, cnt_d;
  logic [CW-1:0] num_cap_q, num_cap_d;
  logic [1:0]    mode_cap_q, mode_cap_d;
  logic [DW-1:0] acc_q, acc_d;
  logic          ph_q, ph_d;
  logic [DW-1:0] dout_q, dout_d;
  logic          dvalid_q, dvalid_d;
  logic          out2_q, out2_d;

  logic          first;
  logic          last;
  logic [CW-1:0] win_num;
  logic [1:0]    win_mode;
  logic [DW-1:0] acc_upd;
  logic [DW-1:0] acc_nxt;

  always_comb begin
    // At cnt=0 the live num/mode are the ones being captured, so they govern this cycle too.
    first    = (cnt_q == '0);
    win_num  = first ? num  : num_cap_q;
    win_mode = first ? mode : mode_cap_q;

    case (win_mode)
      2'b01:   acc_upd = (din > acc_q) ? din : acc_q;
      2'b10:   acc_upd = (din < acc_q) ? din : acc_q;
      default: acc_upd = din;
    endcase
    acc_nxt = first ? din : acc_upd;
    // Comparing against captured num avoids needing a CW+1 bit window length.
    last    = (cnt_q == win_num);

    cnt_d      = cnt_q;
    num_cap_d  = num_cap_q;
    mode_cap_d = mode_cap_q;
    acc_d      = acc_q;
    ph_d       = ph_q;
    dout_d     = dout_q;
    dvalid_d   = 1'b0;
    out2_d     = 1'b0;

    if (!en) begin
      cnt_d = '0;
      acc_d = '0;
      ph_d  = 1'b0;
    end else begin
      num_cap_d  = win_num;
      mode_cap_d = win_mode;
      acc_d      = acc_nxt;
      cnt_d      = last ? '0 : cnt_q + 1'b1;
      if (last) begin
        dout_d   = acc_nxt;
        out2_d   = 1'b1;
        dvalid_d = ~div2 | ph_q;
        ph_d     = ~ph_q;
      end
    end
  end

  always_ff @(posedge clk or negedge nrst) begin
    if (!nrst) begin
      cnt_q      <= '0;
      num_cap_q  <= '0;
      mode_cap_q <= 2'b00;
      acc_q      <= '0;
      ph_q       <= 1'b0;
      dout_q     <= '0;
      dvalid_q   <= 1'b0;
      out2_q     <= 1'b0;
    end else begin
      cnt_q      <= cnt_d;
      num_cap_q  <= num_cap_d;
      mode_cap_q <= mode_cap_d;
      acc_q      <= acc_d;
      ph_q       <= ph_d;
      dout_q     <= dout_d;
      dvalid_q   <= dvalid_d;
      out2_q     <= out2_d;
    end
  end

  assign dout   = dout_q;
  assign dvalid = dvalid_q;
  assign out2   = out2_q;

endmodule

// File: tb/tb_smpl_deci_pk.sv
// Directed bench for smpl_deci_pk: window lengths, reduction modes, div2 phasing, en/reset aborts.
module tb_smpl_deci_pk;
  localparam int DW = 8;
  localparam int CW = 16;

  logic          clk = 1'b0;
  logic          nrst;
  logic          en;
  logic [CW-1:0] num;
  logic [1:0]    mode;
  logic          div2;
  logic [DW-1:0] din;
  logic [DW-1:0] dout;
  logic          dvalid;
  logic          out2;

  int n_chk  = 0;
  int n_pass = 0;

  smpl_deci_pk #(.DW(DW), .CW(CW)) dut (
    .clk(clk), .nrst(nrst), .en(en), .num(num), .mode(mode), .div2(div2),
    .din(din), .dout(dout), .dvalid(dvalid), .out2(out2)
  );

  always #5 clk = ~clk;

  task automatic tick(input logic [DW-1:0] d);
    din = d;
    @(posedge clk);
    #1;
  endtask

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_chk++;
    assert (obs === exp) n_pass++;
    else $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
  endtask

  logic [DW-1:0] v27 [8];
  int n_dv;
  logic last_dv;

  initial begin
    v27[0] = 8'd3; v27[1] = 8'd9; v27[2] = 8'd1; v27[3] = 8'd4;
    v27[4] = 8'd7; v27[5] = 8'd2; v27[6] = 8'd8; v27[7] = 8'd0;

    // reset
    nrst = 1'b0; en = 1'b0; num = 16'd5; mode = 2'b00; div2 = 1'b0; din = 8'hAA;
    #1;
    chk("rst_dout", 32'(dout), 32'h0);
    chk("rst_dvalid", 32'(dvalid), 32'h0);
    chk("rst_out2", 32'(out2), 32'h0);
    tick(8'h55);
    tick(8'h55);
    nrst = 1'b1;
    tick(8'h55);
    chk("idle_dvalid", 32'(dvalid), 32'h0);

    // plain ramp, L=6
    en = 1'b1;
    for (int i = 0; i < 18; i++) begin
      tick(8'(i));
      chk("ramp_dvalid", 32'(dvalid), 32'((i % 6) == 5));
      chk("ramp_out2", 32'(out2), 32'((i % 6) == 5));
      if ((i % 6) == 5) chk("ramp_dout", 32'(dout), 32'(i));
    end

    // peak max then peak min, L=4
    en = 1'b0; tick(8'h0); en = 1'b1;
    num = 16'd3; mode = 2'b01;
    for (int i = 0; i < 8; i++) begin
      tick(v27[i]);
      if (i == 3) chk("max_w0", 32'(dout), 32'd9);
      if (i == 7) chk("max_w1", 32'(dout), 32'd8);
      chk("max_dvalid", 32'(dvalid), 32'((i % 4) == 3));
    end
    mode = 2'b10;
    for (int i = 0; i < 8; i++) begin
      tick(v27[i]);
      if (i == 3) chk("min_w0", 32'(dout), 32'd1);
      if (i == 7) chk("min_w1", 32'(dout), 32'd0);
    end

    // div2 with L=6
    en = 1'b0; tick(8'h0); en = 1'b1;
    num = 16'd5; mode = 2'b00; div2 = 1'b1;
    for (int i = 0; i < 24; i++) begin
      tick(8'(i));
      chk("d2_out2", 32'(out2), 32'((i % 6) == 5));
      chk("d2_dvalid", 32'(dvalid), 32'((i % 12) == 11));
      if ((i % 12) == 11) chk("d2_dout", 32'(dout), 32'(i));
    end

    // num=0: every cycle is a window end
    en = 1'b0; tick(8'h0); en = 1'b1;
    num = 16'd0; mode = 2'b01; div2 = 1'b0;
    for (int i = 0; i < 6; i++) begin
      tick(8'(10 + i));
      chk("n0_dvalid", 32'(dvalid), 32'h1);
      chk("n0_dout", 32'(dout), 32'(10 + i));
    end
    en = 1'b0; tick(8'h0); en = 1'b1;
    div2 = 1'b1;
    for (int i = 0; i < 6; i++) begin
      tick(8'(20 + i));
      chk("n0d2_out2", 32'(out2), 32'h1);
      chk("n0d2_dvalid", 32'(dvalid), 32'(i % 2));
    end

    // num change mid-window
    en = 1'b0; tick(8'h0); en = 1'b1;
    num = 16'd5; mode = 2'b00; div2 = 1'b0;
    for (int i = 0; i < 12; i++) begin
      if (i == 3) num = 16'd2;
      tick(8'(i));
      chk("nchg_dvalid", 32'(dvalid), 32'(i == 5 || i == 8 || i == 11));
      if (i == 5 || i == 8 || i == 11) chk("nchg_dout", 32'(dout), 32'(i));
    end

    // en dropped mid-window: partial window discarded, dout holds
    num = 16'd5;
    for (int i = 0; i < 4; i++) tick(8'(50 + i));
    en = 1'b0;
    tick(8'h77);
    chk("endrop_dvalid", 32'(dvalid), 32'h0);
    chk("endrop_out2", 32'(out2), 32'h0);
    chk("endrop_dout_hold", 32'(dout), 32'd11);
    en = 1'b1;
    for (int i = 0; i < 6; i++) begin
      tick(8'(100 + i));
      chk("restart_dvalid", 32'(dvalid), 32'(i == 5));
    end
    chk("restart_dout", 32'(dout), 32'd105);

    // async reset mid-window
    for (int i = 0; i < 3; i++) tick(8'(150 + i));
    nrst = 1'b0;
    #1;
    chk("arst_dout", 32'(dout), 32'h0);
    chk("arst_dvalid", 32'(dvalid), 32'h0);
    chk("arst_out2", 32'(out2), 32'h0);
    tick(8'd160);
    chk("arst_hold_dout", 32'(dout), 32'h0);
    nrst = 1'b1;
    for (int i = 0; i < 6; i++) begin
      tick(8'(200 + i));
      chk("postrst_dvalid", 32'(dvalid), 32'(i == 5));
    end
    chk("postrst_dout", 32'(dout), 32'd205);

    // maximum window length 2^CW
    en = 1'b0; tick(8'h0); en = 1'b1;
    num = 16'hFFFF; mode = 2'b00; div2 = 1'b0;
    n_dv = 0; last_dv = 1'b0;
    for (int i = 0; i < 65536; i++) begin
      tick(8'(i));
      if (dvalid) n_dv++;
      last_dv = dvalid;
    end
    chk("big_count", 32'(n_dv), 32'd1);
    chk("big_last", 32'(last_dv), 32'h1);
    chk("big_dout", 32'(dout), 32'hFF);

    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end

endmodule
